cordiv_sched: RTL and testbench
===============================

# cordiv_sched

Job controller for a CORDIV stochastic divider. It accepts a binary dividend/divisor pair over a valid/ready handshake and generates correlated unary bitstreams from one shared low-discrepancy source. It runs an internal CORDIV datapath for a full 2^WIDTH-cycle stream, counts quotient ones, and returns the binary quotient over a second valid/ready handshake. It sits between binary-domain producers and consumers and the unary divider datapath.

## Interface
- WIDTH, 8: operand/result width; stream length is 2^WIDTH cycles
- SRDEPTH, 2: CORDIV shift-register depth (2 or more)
- WARMUP, 4: warm-up cycles; used only with the configuration macro
- clk  input  1  clock
- rst  input  1  reset; one clock; reset is asynchronous and active-high
- in_valid  input  1  job request
- in_ready  output  1  controller can accept a job
- in_dividend  input  WIDTH  dividend value in [0, 2^WIDTH)
- in_divisor  input  WIDTH  divisor value in [0, 2^WIDTH)
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_quotient  output  WIDTH  quotient scaled by 2^WIDTH, saturated
- out_err  output  1  job rejected (divisor 0 or dividend > divisor)
- busy  output  1  state is not IDLE

## Operation
- States: IDLE, WARM (macro only), RUN, DONE.
- IDLE: in_ready=1. A job is accepted when in_valid&&in_ready; the operands are latched.
- On accept with divisor==0 or dividend>divisor: next state is DONE with out_err=1 and out_quotient=all ones. No stream is run.
- On a valid accept:
  - rng_cnt clears to 0.
  - The quotient ones-counter (WIDTH+1 bits) clears.
  - The CORDIV shift register clears synchronously.
  - Next state is RUN (WARM when the macro is defined).
- Every RUN cycle:
  - rng = bit-reverse(rng_cnt).
  - dvd_bit = (dividend_reg > rng) and dvs_bit = (divisor_reg > rng). Both bits come from the same rng, so they are positively correlated as CORDIV requires.
  - sel = LSB of a free-running 16-bit Fibonacci LFSR with taps 16,14,13,11. The LFSR loads seed 16'hACE1 on reset only and advances every cycle.
  - The sel index covers SRDEPTH entries; when SRDEPTH > 2, sel uses the low log2(SRDEPTH) LFSR bits.
  - q = dvs_bit ? dvd_bit : sr[sel].
  - When dvs_bit=1, the shift register shifts q in at index 0; otherwise it holds.
  - The ones-counter adds q; rng_cnt increments.
- RUN lasts exactly 2^WIDTH cycles. After the cycle with rng_cnt == 2^WIDTH-1, the next state is DONE.
- Entering DONE: out_quotient = min(count, 2^WIDTH-1) and out_err=0. Both are registered and stable while out_valid=1.
- DONE: out_valid=1. Moves to IDLE on the edge where out_ready=1. in_ready stays 0 until IDLE.
- in_valid while not IDLE is ignored, and the operands are not sampled. The requester holds its data.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, out_quotient=0, out_err=0, busy=0.
  - Counters and shift register = 0; LFSR = 16'hACE1.
- Valid job latency: out_valid rises 2^WIDTH+1 cycles after the accept edge, or 2^WIDTH+WARMUP+1 with the macro. Example: accept at edge 0 gives out_valid at edge 257 for WIDTH=8.
- Error job latency: out_valid rises 1 cycle after the accept edge.
- out_valid and out_ready high together: the result is consumed and in_ready=1 next cycle. Back-to-back jobs therefore need one IDLE cycle.
- Reset mid-job (any state): the job is dropped and all outputs return to reset values asynchronously. No result is produced.

## Configuration
- CORDIV_SCHED_WARMUP_EN defined:
  - A WARM state runs WARMUP cycles before RUN.
  - Bitstream bits are generated from rng_cnt = 2^WIDTH-WARMUP onward (wrapping) and update the shift register, but are not counted.
  - rng_cnt is 0 on the first RUN cycle.
- Not defined: WARM does not exist, and RUN follows the accept directly.

## Test plan
- WIDTH=8, dividend=0, divisor=200 -> out_valid at accept+257, out_quotient=0, out_err=0.
- dividend=255, divisor=255 -> count 256, out_quotient=255 (saturated), out_err=0.
- dividend=64, divisor=128 -> out_quotient in 112..144, out_err=0. The same result repeats when the job is re-run from the same LFSR state after reset.
- divisor=0 -> out_valid 1 cycle after accept, out_quotient=255, out_err=1. Same response for dividend=10, divisor=5.
- Hold out_ready=0 for 20 cycles in DONE -> out_valid and out_quotient stable, in_ready=0, a new in_valid is ignored. Then pulse out_ready -> in_ready=1 next cycle.
- Assert rst at RUN cycle 100 -> all outputs at reset values immediately. A following job returns the same result as the same job from a clean reset.

Source files
------------

// File: rtl/cordiv_sched_if.sv
// cordiv_sched_if: job request / result handshake bundle for cordiv_sched.
// master = job producer/result consumer side, slave = the controller.
interface cordiv_sched_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_dividend;
  logic [WIDTH-1:0] in_divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quotient;
  logic             out_err;

  modport master (
    output in_valid, in_dividend, in_divisor, out_ready,
    input  in_ready, out_valid, out_quotient, out_err
  );

  modport slave (
    input  in_valid, in_dividend, in_divisor, out_ready,
    output in_ready, out_valid, out_quotient, out_err
  );
endinterface

// File: rtl/cordiv_sched.sv
// cordiv_sched: job controller around a CORDIV stochastic divider.
// Latches a dividend/divisor pair, streams 2^WIDTH correlated unary bits
// from one bit-reversed counter, counts quotient ones and returns the
// saturated binary quotient. Illegal jobs (divisor 0, dividend > divisor)
// are answered immediately with out_err and an all-ones quotient.
// Optional feature macro: CORDIV_SCHED_WARMUP_EN adds a WARM state that
// primes the CORDIV shift register for WARMUP uncounted cycles.
module cordiv_sched #(
  parameter int WIDTH   = 8,
  parameter int SRDEPTH = 2,
  parameter int WARMUP  = 4
) (
  input  logic          clk,
  input  logic          rst,
  cordiv_sched_if.slave bus,
  output logic          busy
);

  // Select index width: one bit covers depth 2, log2 beyond that.
  localparam int SELW = (SRDEPTH > 2) ? $clog2(SRDEPTH) : 1;
  localparam logic [SELW:0] DEPTH_V = SRDEPTH[SELW:0];
  // A misconfigured instance never accepts a job rather than misbehaving.
  localparam bit CFG_OK = (SRDEPTH >= 2) && (WARMUP >= 1) && (WARMUP <= (1 << WIDTH));
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

`ifdef CORDIV_SCHED_WARMUP_EN
  // Warm-up starts WARMUP counts before the wrap so RUN begins at rng_cnt 0.
  localparam logic [WIDTH-1:0] CNT_START = WIDTH'((1 << WIDTH) - WARMUP);
`else
  localparam logic [WIDTH-1:0] CNT_START = '0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
`ifdef CORDIV_SCHED_WARMUP_EN
    S_WARM = 2'd3,
`endif
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] dvd_r, dvs_r;
  logic [WIDTH-1:0] rng_cnt;
  logic [WIDTH-1:0] rng;
  logic [WIDTH:0]   ones_cnt;
  logic [WIDTH:0]   ones_nxt;
  logic [SRDEPTH-1:0] sr;
  logic [15:0]      lfsr;
  logic [SELW:0]    sel_ext;
  logic [SELW-1:0]  sel;
  logic [WIDTH-1:0] quot_r;
  logic             err_r;

  logic accept, bad_job, last_cnt, gen, counting;
  logic dvd_bit, dvs_bit, q_bit, lfsr_fb;

  assign accept   = bus.in_valid && (state == S_IDLE) && CFG_OK;
  assign bad_job  = (bus.in_divisor == '0) || (bus.in_dividend > bus.in_divisor);
  assign last_cnt = &rng_cnt;
  assign counting = (state == S_RUN);
`ifdef CORDIV_SCHED_WARMUP_EN
  assign gen      = (state == S_RUN) || (state == S_WARM);
`else
  assign gen      = (state == S_RUN);
`endif
  assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Bitstream generation: shared low-discrepancy rng, CORDIV select and output bit.
  always_comb begin
    rng = '0;
    for (int i = 0; i < WIDTH; i++) rng[i] = rng_cnt[WIDTH-1-i];
    dvd_bit = (dvd_r > rng);
    dvs_bit = (dvs_r > rng);
    sel_ext = {1'b0, lfsr[SELW-1:0]};
    if (sel_ext >= DEPTH_V) sel_ext = sel_ext - DEPTH_V;
    sel     = sel_ext[SELW-1:0];
    q_bit   = dvs_bit ? dvd_bit : sr[sel];
    ones_nxt = ones_cnt + {{WIDTH{1'b0}}, q_bit};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b1;
    case (state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        busy         = 1'b0;
        if (accept) begin
          if (bad_job) state_nxt = S_DONE;
`ifdef CORDIV_SCHED_WARMUP_EN
          else         state_nxt = S_WARM;
`else
          else         state_nxt = S_RUN;
`endif
        end
      end
`ifdef CORDIV_SCHED_WARMUP_EN
      S_WARM:  if (last_cnt) state_nxt = S_RUN;
`endif
      S_RUN:   if (last_cnt) state_nxt = S_DONE;
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand latch, LFSR, stream counter, CORDIV register, result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_r    <= '0;
      dvs_r    <= '0;
      rng_cnt  <= '0;
      ones_cnt <= '0;
      sr       <= '0;
      lfsr     <= LFSR_SEED;
      quot_r   <= '0;
      err_r    <= 1'b0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
      if (accept) begin
        dvd_r    <= bus.in_dividend;
        dvs_r    <= bus.in_divisor;
        rng_cnt  <= CNT_START;
        ones_cnt <= '0;
        sr       <= '0;
        if (bad_job) begin
          quot_r <= '1;
          err_r  <= 1'b1;
        end
      end else if (gen) begin
        rng_cnt <= rng_cnt + WIDTH'(1);
        if (dvs_bit) sr <= {sr[SRDEPTH-2:0], q_bit};
        if (counting) begin
          ones_cnt <= ones_nxt;
          if (last_cnt) begin
            quot_r <= ones_nxt[WIDTH] ? '1 : ones_nxt[WIDTH-1:0];
            err_r  <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.out_quotient = quot_r;
  assign bus.out_err      = err_r;

endmodule

// File: tb/tb_cordiv_sched.sv
// tb_cordiv_sched: directed table-driven bench for cordiv_sched plus
// hand-written sequences for result hold, mid-job reset and repeatability.
module tb_cordiv_sched;
  localparam int WIDTH   = 8;
  localparam int SRDEPTH = 2;
  localparam int WARMUP  = 4;
`ifdef CORDIV_SCHED_WARMUP_EN
  localparam int RUN_LAT = (1 << WIDTH) + WARMUP + 1;
`else
  localparam int RUN_LAT = (1 << WIDTH) + 1;
`endif
  localparam int BUDGET  = RUN_LAT + 40;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  cordiv_sched_if #(.WIDTH(WIDTH)) bus ();

  cordiv_sched #(.WIDTH(WIDTH), .SRDEPTH(SRDEPTH), .WARMUP(WARMUP)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    dvd;
    int    dvs;
    int    q_lo;
    int    q_hi;
    int    err;
    int    lat;
  } vec_t;

  vec_t vecs[7];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_dividend = '0;
    bus.in_divisor  = '0;
    bus.out_ready   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Present a job for one cycle, then count edges from the start of the
  // request cycle until out_valid is seen. abort_at > 0 returns early.
  task automatic run_job(input int dvd, input int dvs, input int abort_at,
                         output int lat, output int q, output int err);
    @(posedge clk); #1;
    bus.in_valid    = 1'b1;
    bus.in_dividend = WIDTH'(dvd);
    bus.in_divisor  = WIDTH'(dvs);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < BUDGET) begin
      if (abort_at != 0 && lat == abort_at) break;
      if (lat == 20) chk("busy_in_run", int'(busy), 1);
      @(posedge clk); #1;
      lat++;
    end
    q   = int'(bus.out_quotient);
    err = int'(bus.out_err);
  endtask

  task automatic consume(input string name);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({name, "_in_ready_after"}, int'(bus.in_ready), 1);
    chk({name, "_out_valid_after"}, int'(bus.out_valid), 0);
  endtask

  initial begin
    int lat, q, err, q_ref, q0;
    bit hold_ok;

    vecs[0] = '{"zero_dividend",   0, 200,   0,   0, 0, RUN_LAT};
    vecs[1] = '{"full_255",      255, 255, 255, 255, 0, RUN_LAT};
    vecs[2] = '{"full_254",      254, 254, 255, 255, 0, RUN_LAT};
    vecs[3] = '{"zero_div1",       0,   1,   0,   0, 0, RUN_LAT};
    vecs[4] = '{"half",           64, 128, 112, 144, 0, RUN_LAT};
    vecs[5] = '{"divisor_zero",    0,   0, 255, 255, 1, 1};
    vecs[6] = '{"dvd_gt_dvs",     10,   5, 255, 255, 1, 1};

    do_reset();
    chk("rst_in_ready",     int'(bus.in_ready), 1);
    chk("rst_out_valid",    int'(bus.out_valid), 0);
    chk("rst_out_quotient", int'(bus.out_quotient), 0);
    chk("rst_out_err",      int'(bus.out_err), 0);
    chk("rst_busy",         int'(busy), 0);

    for (int i = 0; i < 7; i++) begin
      run_job(vecs[i].dvd, vecs[i].dvs, 0, lat, q, err);
      chk({vecs[i].name, "_latency"}, lat, vecs[i].lat);
      chk_rng({vecs[i].name, "_quotient"}, q, vecs[i].q_lo, vecs[i].q_hi);
      chk({vecs[i].name, "_err"}, err, vecs[i].err);
      consume(vecs[i].name);
    end

    // Result held in DONE while the consumer stalls; new requests ignored.
    run_job(0, 0, 0, lat, q0, err);
    chk("hold_setup_latency", lat, 1);
    bus.in_valid    = 1'b1;
    bus.in_dividend = 8'd1;
    bus.in_divisor  = 8'd2;
    hold_ok = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (!bus.out_valid || int'(bus.out_quotient) != 255 || !bus.out_err ||
          bus.in_ready || !busy) hold_ok = 1'b0;
    end
    chk("hold_stable", int'(hold_ok), 1);
    bus.in_valid = 1'b0;
    consume("hold");
    @(posedge clk); #1;
    chk("hold_ignored_job_busy", int'(busy), 0);

    // Reference run from a clean reset.
    do_reset();
    run_job(64, 128, 0, lat, q_ref, err);
    chk("ref_latency", lat, RUN_LAT);
    chk_rng("ref_quotient", q_ref, 112, 144);
    consume("ref");

    // Same job, reset asynchronously 100 cycles into the run.
    do_reset();
    run_job(64, 128, 100, lat, q, err);
    chk("abort_reached", lat, 100);
    #2 rst = 1'b1;
    #1;
    chk("abort_in_ready",  int'(bus.in_ready), 1);
    chk("abort_out_valid", int'(bus.out_valid), 0);
    chk("abort_quotient",  int'(bus.out_quotient), 0);
    chk("abort_err",       int'(bus.out_err), 0);
    chk("abort_busy",      int'(busy), 0);

    // Rerun after reset must reproduce the reference job exactly.
    do_reset();
    run_job(64, 128, 0, lat, q, err);
    chk("rerun_latency", lat, RUN_LAT);
    chk("rerun_quotient", q, q_ref);
    chk("rerun_err", err, 0);
    consume("rerun");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
